flappy_game_ctrl: RTL

Per-frame game sequencer for the flappy bird display path. Runs on the 25 MHz VGA pixel clock and advances the game once per video frame, on the vsync falling edge. Takes flap requests from the debounced button, optionally from the camera hand tracker, and a collision flag from the pixel renderer. Produces the bird position, pipe position/gap, score and game state that the renderer draws.

---
 rtl/flappy_game_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl: per-frame game sequencer; all game state advances once per frame on the vsync falling edge.
// Build option: define HAND_CTRL_EN to let the camera hand tracker (hand_y/hand_valid) issue flaps.

module flappy_game_ctrl #(
   parameter int unsigned H_RES       = 640,
   parameter int unsigned V_RES       = 480,
   parameter int unsigned BIRD_X      = 160,
   parameter int unsigned BIRD_H      = 16,
   parameter int unsigned PIPE_W      = 64,
   parameter int unsigned PIPE_SPEED  = 2,
   parameter int unsigned GRAVITY     = 1,
   parameter int unsigned FLAP_VEL    = 8,
   parameter int unsigned V_MAX       = 10,
   parameter int unsigned DEAD_FRAMES = 60,
   parameter int unsigned HAND_THR    = 160
) (
   input  logic       vga_clk,
   input  logic       sys_rst,
   input  logic       vsync,
   input  logic       flap_btn,
   input  logic       hit,
   input  logic [9:0] hand_y,
   input  logic       hand_valid,
   output logic       frame_tick,
   output logic [1:0] game_state,
   output logic [9:0] bird_y,
   output logic [9:0] pipe_x,
   output logic [9:0] gap_y,
   output logic [7:0] score
);

   localparam int unsigned DW = $clog2(DEAD_FRAMES + 1);

   localparam logic [9:0]         Y_HOME    = 10'((V_RES - BIRD_H) / 2);
   localparam logic [9:0]         Y_FLOOR   = 10'(V_RES - BIRD_H);
   localparam logic signed [10:0] NY_FLOOR  = 11'(V_RES - BIRD_H);
   localparam logic [9:0]         PIPE_HOME = 10'(H_RES);
   localparam logic [9:0]         GAP_HOME  = 10'd176;
   localparam logic [9:0]         GAP_BASE  = 10'd48;
   localparam logic [9:0]         SPEED     = 10'(PIPE_SPEED);
   localparam logic [10:0]        PIPE_W11  = 11'(PIPE_W);
   localparam logic [10:0]        BIRD_X11  = 11'(BIRD_X);
   localparam logic signed [7:0]  VEL_FLAP  = 8'(0 - FLAP_VEL);
   localparam logic signed [7:0]  VEL_GRAV  = 8'(GRAVITY);
   localparam logic signed [7:0]  VEL_MAX   = 8'(V_MAX);
   localparam logic [DW-1:0]      DEAD_LAST = DW'(DEAD_FRAMES - 1);
   localparam logic [7:0]         LFSR_SEED = 8'hA5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_DEAD = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic              vsync_d;
   logic              tick;
   logic              btn_d;
   logic              btn_rise;
   logic              hand_rise;
   logic              flap_req;
   logic              flap_pend;
   logic              hit_pend;
   logic              launch, launch_nxt;
   logic [7:0]        lfsr;
   logic              lfsr_fb;
   logic signed [7:0] vel, vel_nxt, vel_fall;
   logic signed [10:0] ny;
   logic [10:0]       old_edge, new_edge;
   logic [9:0]        bird_nxt, pipe_nxt, gap_nxt;
   logic [7:0]        score_nxt;
   logic [DW-1:0]     dead_cnt, dead_nxt;

   assign tick       = vsync_d & ~vsync;
   assign btn_rise   = flap_btn & ~btn_d;
   assign flap_req   = btn_rise | hand_rise;
   assign lfsr_fb    = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
   assign game_state = state;

`ifdef HAND_CTRL_EN
   logic above, above_d;

   always_ff @(posedge vga_clk) begin
      if (sys_rst) begin
         above   <= 1'b0;
         above_d <= 1'b0;
      end else begin
         above   <= hand_valid & (hand_y < 10'(HAND_THR));
         above_d <= above;
      end
   end

   assign hand_rise = above & ~above_d;
`else
   logic unused_hand;

   assign unused_hand = ^{hand_y, hand_valid, 10'(HAND_THR)};
   assign hand_rise   = 1'b0;
`endif

   always_ff @(posedge vga_clk) begin
      if (sys_rst) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      vel_nxt    = vel;
      bird_nxt   = bird_y;
      pipe_nxt   = pipe_x;
      gap_nxt    = gap_y;
      score_nxt  = score;
      dead_nxt   = dead_cnt;
      launch_nxt = launch;
      vel_fall   = vel + VEL_GRAV;
      ny         = '0;
      old_edge   = {1'b0, pipe_x} + PIPE_W11;
      new_edge   = '0;
      if (tick) begin
         case (state)
            S_IDLE: begin
               if (flap_pend) begin
                  state_nxt  = S_PLAY;
                  vel_nxt    = VEL_FLAP;
                  score_nxt  = '0;
                  pipe_nxt   = PIPE_HOME;
                  launch_nxt = 1'b1;
               end
            end
            S_PLAY: begin
               // The starting flap's velocity is applied as-is on the first PLAY tick (no gravity step).
               launch_nxt = 1'b0;
               if ((launch || flap_pend) && !hit_pend) vel_nxt = VEL_FLAP;
               else if (vel_fall > VEL_MAX)            vel_nxt = VEL_MAX;
               else                                    vel_nxt = vel_fall;
               ny = $signed({1'b0, bird_y}) + $signed({{3{vel_nxt[7]}}, vel_nxt});
               if (ny[10]) begin
                  bird_nxt = '0;
               end else if (ny >= NY_FLOOR) begin
                  bird_nxt  = Y_FLOOR;
                  state_nxt = S_DEAD;
               end else begin
                  bird_nxt = ny[9:0];
               end
               if (hit_pend) state_nxt = S_DEAD;
               if (pipe_x < SPEED) begin
                  pipe_nxt = PIPE_HOME;
                  gap_nxt  = GAP_BASE + {2'b00, lfsr};
               end else begin
                  pipe_nxt = pipe_x - SPEED;
                  new_edge = {1'b0, pipe_nxt} + PIPE_W11;
                  if (old_edge > BIRD_X11 && new_edge <= BIRD_X11 && score != 8'hFF)
                     score_nxt = score + 8'd1;
               end
               dead_nxt = '0;
            end
            S_DEAD: begin
               if (dead_cnt == DEAD_LAST) begin
                  state_nxt = S_IDLE;
                  dead_nxt  = '0;
                  bird_nxt  = Y_HOME;
                  vel_nxt   = '0;
                  pipe_nxt  = PIPE_HOME;
               end else begin
                  dead_nxt = dead_cnt + DW'(1);
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge vga_clk) begin
      if (sys_rst) begin
         vsync_d    <= 1'b0;
         btn_d      <= 1'b0;
         frame_tick <= 1'b0;
         flap_pend  <= 1'b0;
         hit_pend   <= 1'b0;
         launch     <= 1'b0;
         lfsr       <= LFSR_SEED;
         vel        <= '0;
         bird_y     <= Y_HOME;
         pipe_x     <= PIPE_HOME;
         gap_y      <= GAP_HOME;
         score      <= '0;
         dead_cnt   <= '0;
      end else begin
         vsync_d    <= vsync;
         btn_d      <= flap_btn;
         frame_tick <= tick;
         // A request landing on the tick cycle itself belongs to the next frame.
         flap_pend  <= tick ? flap_req : (flap_pend | flap_req);
         hit_pend   <= tick ? hit : (hit_pend | hit);
         launch     <= launch_nxt;
         lfsr       <= {lfsr[6:0], lfsr_fb};
         vel        <= vel_nxt;
         bird_y     <= bird_nxt;
         pipe_x     <= pipe_nxt;
         gap_y      <= gap_nxt;
         score      <= score_nxt;
         dead_cnt   <= dead_nxt;
      end
   end

endmodule
